arm7_mem_responder: RTL and testbench

ARM7_MEM_RESPONDER -- requirements
Module: arm7_mem_responder

---
 rtl/arm7_mem_responder_pkg.sv | 29 ++
 rtl/arm7_mem_responder_array.sv | 34 +++
 rtl/arm7_mem_responder.sv | 219 +++++++++++++++++++++
 tb/tb_arm7_mem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm7_mem_responder_pkg.sv
// Shared types and constants for the ARM7 memory responder slice.
package arm7tdmi_pkg;

  localparam int unsigned MEM_RESP_MAX_WAIT = 15;
  localparam int unsigned MEM_RESP_CNT_W    = 4;

  typedef enum logic [1:0] {
    MEM_RESP_IDLE = 2'd0,
    MEM_RESP_WAIT = 2'd1,
    MEM_RESP_DONE = 2'd2
  } mem_resp_state_t;

  // Merge new data into an old word, byte lane i taken from nw when be[i] is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old,
                                           input logic [31:0] nw,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = nw[8*i +: 8];
      end else begin
        res[8*i +: 8] = old[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arm7_mem_responder_array.sv
// Byte-enabled word RAM: asynchronous read, CPU write port plus preload write port.
module arm7_mem_array
  import arm7tdmi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          load_we,
  input  logic [AW-1:0] load_idx,
  input  logic [31:0]   load_data,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_idx,
  input  logic [3:0]    cpu_be,
  input  logic [31:0]   cpu_wdata,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Load is scheduled after the CPU write so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (cpu_we) begin
      mem_q[cpu_idx] <= be_merge(mem_q[cpu_idx], cpu_wdata, cpu_be);
    end
    if (load_we) begin
      mem_q[load_idx] <= load_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/arm7_mem_responder.sv
// ARM7 memory-bus slave with preload port. Define ARM7_MEM_WAIT_EN for the
// wait-state FSM; otherwise ready is constant and reads are combinational.
module arm7_mem_responder
  import arm7tdmi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned DEFAULT_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [3:0]  mem_be,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        wait_we,
  input  logic [3:0]  wait_din,
  output logic        err_flag
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [AW-1:0] req_idx_s;
  logic          req_oor_s;
  logic          load_ok_s;
  logic [AW-1:0] rd_idx_s;
  logic [31:0]   rd_data_s;
  logic          cpu_we_s;
  logic [AW-1:0] cpu_idx_s;
  logic [3:0]    cpu_be_s;
  logic [31:0]   cpu_wdata_s;
  logic          unused_bits_s;

  assign req_idx_s = mem_addr[AW+1:2];
  assign req_oor_s = (mem_addr[31:2] >= 30'(DEPTH_WORDS));
  // Out-of-range preloads are dropped rather than aliased onto low words.
  assign load_ok_s = load_we & (load_addr < 32'(DEPTH_WORDS));

  arm7_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk      (clk),
    .load_we  (load_ok_s),
    .load_idx (load_addr[AW-1:0]),
    .load_data(load_data),
    .cpu_we   (cpu_we_s),
    .cpu_idx  (cpu_idx_s),
    .cpu_be   (cpu_be_s),
    .cpu_wdata(cpu_wdata_s),
    .rd_idx   (rd_idx_s),
    .rd_data  (rd_data_s)
  );

`ifdef ARM7_MEM_WAIT_EN

  localparam logic [MEM_RESP_CNT_W-1:0] WAIT_RST =
    MEM_RESP_CNT_W'((DEFAULT_WAIT > MEM_RESP_MAX_WAIT) ? MEM_RESP_MAX_WAIT : DEFAULT_WAIT);

  mem_resp_state_t            state_q, state_d;
  logic [MEM_RESP_CNT_W-1:0]  cnt_q, cnt_d;
  logic [MEM_RESP_CNT_W-1:0]  wait_cfg_q, wait_cfg_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [3:0]                 be_q, be_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       we_q, we_d;
  logic                       oor_q, oor_d;
  logic                       ready_q, ready_d;
  logic                       err_q, err_d;
  logic                       rd_ok_s;

  assign unused_bits_s = ^mem_addr[1:0];
  assign rd_idx_s      = (state_q == MEM_RESP_IDLE) ? req_idx_s : addr_q;
  assign cpu_idx_s     = addr_q;
  assign cpu_be_s      = be_q;
  assign cpu_wdata_s   = wdata_q;

  // Next-state, capture and output logic of the wait-state FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    oor_d    = oor_q;
    err_d    = err_q;
    rd_ok_s  = 1'b0;
    cpu_we_s = 1'b0;
    if (wait_we) begin
      wait_cfg_d = wait_din;
    end else begin
      wait_cfg_d = wait_cfg_q;
    end
    case (state_q)
      MEM_RESP_IDLE: begin
        rd_ok_s = mem_re & ~mem_we & ~req_oor_s;
        if (mem_re | mem_we) begin
          addr_d  = req_idx_s;
          be_d    = mem_be;
          wdata_d = mem_wdata;
          we_d    = mem_we;
          oor_d   = req_oor_s;
          cnt_d   = wait_cfg_q;
          err_d   = err_q | (mem_re & mem_we) | req_oor_s;
          if (wait_cfg_q == 4'd0) begin
            state_d = MEM_RESP_DONE;
          end else begin
            state_d = MEM_RESP_WAIT;
          end
        end else begin
          state_d = MEM_RESP_IDLE;
        end
      end
      MEM_RESP_WAIT: begin
        rd_ok_s = ~we_q & ~oor_q;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = MEM_RESP_DONE;
        end else begin
          state_d = MEM_RESP_WAIT;
        end
      end
      MEM_RESP_DONE: begin
        // A reset landing on the commit edge must not leave a partial write behind.
        cpu_we_s = we_q & ~oor_q & ~rst;
        state_d  = MEM_RESP_IDLE;
      end
      default: begin
        state_d = MEM_RESP_IDLE;
      end
    endcase
    ready_d = (state_d == MEM_RESP_DONE);
    if (ready_d && rd_ok_s) begin
      rdata_d = rd_data_s;
    end else begin
      rdata_d = 32'd0;
    end
  end

  // State and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEM_RESP_IDLE;
      cnt_q      <= 4'd0;
      wait_cfg_q <= WAIT_RST;
      addr_q     <= '0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_cfg_q <= wait_cfg_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      oor_q      <= oor_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign err_flag  = err_q;

`else

  logic err_q, err_d;

  assign unused_bits_s = ^{mem_addr[1:0], wait_we, wait_din, 32'(DEFAULT_WAIT)};
  assign rd_idx_s      = req_idx_s;
  assign cpu_idx_s     = req_idx_s;
  assign cpu_be_s      = mem_be;
  assign cpu_wdata_s   = mem_wdata;

  // Zero-wait path: write on the edge, read straight from the array.
  always_comb begin
    cpu_we_s = mem_we & ~req_oor_s;
    if ((mem_re & mem_we) | ((mem_re | mem_we) & req_oor_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    if (mem_re & ~mem_we & ~req_oor_s) begin
      mem_rdata = rd_data_s;
    end else begin
      mem_rdata = 32'd0;
    end
  end

  // Sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign mem_ready = 1'b1;
  assign err_flag  = err_q;

`endif

endmodule

// File: tb/tb_arm7_mem_responder.sv
// Self-checking bench for arm7_mem_responder; follows ARM7_MEM_WAIT_EN like the RTL.
module tb_arm7_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, mem_ready;
  logic [3:0]  mem_be;
  logic        load_we;
  logic [31:0] load_addr, load_data;
  logic        wait_we;
  logic [3:0]  wait_din;
  logic        err_flag;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  bit          err_m;
  int          wait_m;

  typedef struct {
    bit          re;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wt;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] rd;
  int          lat;
  bit          seen;

  arm7_mem_responder #(.DEPTH_WORDS(DEPTH), .DEFAULT_WAIT(2)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .wait_we(wait_we), .wait_din(wait_din),
    .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(bit re, bit we, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] be, int wt, logic [31:0] exp_rdata, bit exp_err);
    vec_t v;
    v.re = re; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.wt = wt; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] pat(int i);
    if (i == 0) return 32'h0000_0000;
    if (i == 4) return 32'h46C0_46C0;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Reference behaviour of one CPU transfer: returns the read data it should produce.
  function automatic logic [31:0] model_xfer(bit re, bit we, logic [31:0] addr,
                                             logic [31:0] wdata, logic [3:0] be);
    int unsigned idx;
    bit bad;
    idx = 32'(addr[31:2]);
    bad = (idx >= DEPTH);
    if ((re && we) || bad) err_m = 1'b1;
    if (we) begin
      if (!bad) model[idx] = merge(model[idx], wdata, be);
      return 32'd0;
    end
    return bad ? 32'd0 : model[idx];
  endfunction

  function automatic int exp_lat();
`ifdef ARM7_MEM_WAIT_EN
    return 1 + wait_m;
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_re = 1'b0; mem_we = 1'b0; load_we = 1'b0; wait_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_err", err_flag, 0);
    check("reset_rdata", mem_rdata, 0);
`ifdef ARM7_MEM_WAIT_EN
    check("reset_ready", mem_ready, 0);
`else
    check("reset_ready_const", mem_ready, 1);
`endif
    rst = 1'b0;
    err_m = 1'b0;
    wait_m = 2;
  endtask

  task automatic load_word(input int idx, input logic [31:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = 32'(idx); load_data = d;
    @(negedge clk);
    load_we = 1'b0;
    model[idx] = d;
  endtask

  task automatic set_wait(input int w);
    @(negedge clk);
    wait_we = 1'b1; wait_din = 4'(w);
    @(negedge clk);
    wait_we = 1'b0;
    wait_m = w;
  endtask

  // Polls for the ready strobe (bounded), optionally dropping the request or firing a load on the commit cycle.
  task automatic wait_ready(input int drop_after, input bit coll, input logic [31:0] cl_addr,
                            input logic [31:0] cl_data, output logic [31:0] rdata, output int l);
    bit zero_ok;
    zero_ok = 1'b1;
    l = -1;
    rdata = 32'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      wait_we = 1'b0;
      if (mem_ready === 1'b1) begin
        rdata = mem_rdata;
        l = k;
        if (coll) begin
          load_we = 1'b1; load_addr = cl_addr; load_data = cl_data;
        end
        break;
      end else begin
        if (mem_rdata !== 32'd0) zero_ok = 1'b0;
        if (k == drop_after) begin
          mem_re = 1'b0; mem_we = 1'b0;
        end
      end
    end
    mem_re = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    load_we = 1'b0;
    check("rdata_zero_while_busy", {31'd0, zero_ok}, 1);
    check("ready_single_pulse", mem_ready, 0);
  endtask

  task automatic xfer(input bit re, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int drop_after, input bit coll,
                      input logic [31:0] cl_addr, input logic [31:0] cl_data,
                      output logic [31:0] rdata, output int l);
    @(negedge clk);
    mem_re = re; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_be = be;
`ifdef ARM7_MEM_WAIT_EN
    wait_ready(drop_after, coll, cl_addr, cl_data, rdata, l);
`else
    if (coll) begin
      load_we = 1'b1; load_addr = cl_addr; load_data = cl_data;
    end
    #1;
    rdata = mem_rdata;
    l = (mem_ready === 1'b1) ? drop_after : -1;
    @(negedge clk);
    mem_re = 1'b0; mem_we = 1'b0; load_we = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1;
    mem_addr = 32'd0; mem_wdata = 32'd0; mem_we = 1'b0; mem_re = 1'b0; mem_be = 4'd0;
    load_we = 1'b0; load_addr = 32'd0; load_data = 32'd0; wait_we = 1'b0; wait_din = 4'd0;
    err_m = 1'b0; wait_m = 2;

    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      load_we = 1'b1; load_addr = 32'(i); load_data = pat(i);
      model[i] = pat(i);
    end
    @(negedge clk);
    load_we = 1'b0;

    // Directed vectors; expected values derived by hand from the preload pattern.
    tbl.push_back(mk(1, 0, 32'h0000_0010, 32'h0,         4'hF, 0,  32'h46C0_46C0, 0));
    tbl.push_back(mk(0, 1, 32'h0000_0000, 32'hDEAD_BEEF, 4'h5, 3,  32'h0,         0));
    tbl.push_back(mk(1, 0, 32'h0000_0000, 32'h0,         4'hF, 1,  32'h00AD_00EF, 0));
    tbl.push_back(mk(0, 1, 32'h0000_001C, 32'h1234_5678, 4'hC, 2,  32'h0,         0));
    tbl.push_back(mk(1, 0, 32'h0000_001F, 32'h0,         4'hF, 0,  32'h1234_0007, 0));
    tbl.push_back(mk(0, 1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 0,  32'h0,         0));
    tbl.push_back(mk(1, 0, 32'h0000_0022, 32'h0,         4'hF, 4,  32'hC0DE_0008, 0));
    tbl.push_back(mk(1, 0, 32'h0000_0FFC, 32'h0,         4'hF, 15, 32'hC0DE_03FF, 0));
    tbl.push_back(mk(1, 0, 32'h0001_0000, 32'h0,         4'hF, 0,  32'h0,         1));
    tbl.push_back(mk(0, 1, 32'h0000_1000, 32'h9999_9999, 4'hF, 1,  32'h0,         1));
    tbl.push_back(mk(1, 0, 32'h0000_0000, 32'h0,         4'hF, 0,  32'h00AD_00EF, 1));

    foreach (tbl[i]) begin
      set_wait(tbl[i].wt);
      void'(model_xfer(tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be));
      xfer(tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 0, 1'b0, 32'd0, 32'd0, rd, lat);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_latency", i), lat, exp_lat());
      check($sformatf("tbl%0d_err", i), err_flag, tbl[i].exp_err);
    end

    // Preload and CPU commit hit word 7 on the same edge: preload must win.
    set_wait(0);
    xfer(0, 1, 32'h0000_001C, 32'h1111_1111, 4'hF, 0, 1'b1, 32'd7, 32'hAAAA_5555, rd, lat);
    model[7] = 32'hAAAA_5555;
    xfer(1, 0, 32'h0000_001C, 32'h0, 4'hF, 0, 1'b0, 32'd0, 32'd0, rd, lat);
    check("collision_load_wins", rd, 32'hAAAA_5555);

    do_reset();
    // Read and write together is a write plus a sticky error.
    void'(model_xfer(1, 1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF));
    xfer(1, 1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF, 0, 1'b0, 32'd0, 32'd0, rd, lat);
    check("both_rdata", rd, 32'h0);
    check("both_err", err_flag, 1);
    xfer(1, 0, 32'h0000_0040, 32'h0, 4'hF, 0, 1'b0, 32'd0, 32'd0, rd, lat);
    check("both_is_write", rd, 32'h0BAD_F00D);
    check("both_err_sticky", err_flag, 1);

`ifdef ARM7_MEM_WAIT_EN
    // Request withdrawn mid-wait still completes.
    set_wait(3);
    void'(model_xfer(0, 1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF));
    xfer(0, 1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 1, 1'b0, 32'd0, 32'd0, rd, lat);
    check("drop_latency", lat, 4);
    xfer(1, 0, 32'h0000_0030, 32'h0, 4'hF, 0, 1'b0, 32'd0, 32'd0, rd, lat);
    check("drop_write_done", rd, 32'hCAFE_F00D);

    // A wait update sampled together with a request applies only to the next one.
    set_wait(1);
    @(negedge clk);
    mem_re = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0010; mem_be = 4'hF;
    wait_we = 1'b1; wait_din = 4'd5;
    wait_ready(0, 1'b0, 32'd0, 32'd0, rd, lat);
    check("wcfg_old_latency", lat, 2);
    check("wcfg_old_rdata", rd, 32'h46C0_46C0);
    xfer(1, 0, 32'h0000_0010, 32'h0, 4'hF, 0, 1'b0, 32'd0, 32'd0, rd, lat);
    check("wcfg_new_latency", lat, 6);

    // Reset while the write waits: nothing commits and no strobe appears.
    set_wait(3);
    @(negedge clk);
    mem_we = 1'b1; mem_re = 1'b0; mem_addr = 32'h0000_0008; mem_wdata = 32'h1234_5678; mem_be = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; mem_we = 1'b0;
    @(negedge clk);
    rst = 1'b0; err_m = 1'b0; wait_m = 2;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_ready !== 1'b0) seen = 1'b1;
    end
    check("rst_wait_no_ready", {31'd0, seen}, 0);
    check("rst_wait_err_clear", err_flag, 0);
    xfer(1, 0, 32'h0000_0008, 32'h0, 4'hF, 0, 1'b0, 32'd0, 32'd0, rd, lat);
    check("rst_wait_word2", rd, 32'hC0DE_0002);
    check("rst_wait_default_lat", lat, 3);
`else
    @(negedge clk);
    mem_re = 1'b0; mem_we = 1'b0;
    #1;
    check("idle_rdata_zero", mem_rdata, 0);
    check("idle_ready_const", mem_ready, 1);
`endif

    // Randomised traffic against the reference model.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      int op;
      logic [31:0] a, d, e;
      logic [3:0] b;
      bit re, we;
      if ($urandom_range(0, 9) == 0) set_wait(int'($urandom_range(0, 4)));
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 99) < 8)
        a = 32'($urandom_range(DEPTH, DEPTH + 5000)) << 2;
      else
        a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      if (op == 9) begin
        load_word(int'($urandom_range(0, DEPTH - 1)), d);
      end else begin
        re = (op <= 3) || (op == 8);
        we = (op >= 4);
        e = model_xfer(re, we, a, d, b);
        xfer(re, we, a, d, b, 0, 1'b0, 32'd0, 32'd0, rd, lat);
        check("rand_rdata", rd, e);
        check("rand_latency", lat, exp_lat());
        check("rand_err", err_flag, err_m);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
